spi_cmd_ctrl: RTL

Command sequencer between the SPI slave word interface and the accelerator register file. Decodes 16-bit header words from the SPI receive side and issues burst writes or reads on a simple register port. Returns read data and status words to the SPI transmit side using the slave's edge-detected valid/ready handshake. Aborts cleanly when chip select deasserts mid-frame.

---
 rtl/spi_cmd_pkg.sv | 48 ++++
 rtl/sync_2ff.sv | 31 +++
 rtl/spi_cmd_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// ============================================================
// spi_cmd_pkg: shared types and header layout for spi_cmd_ctrl
// Revision: 1.0
// ============================================================
`default_nettype none

package spi_cmd_pkg;

    localparam int HDR_WIDTH    = 16;
    localparam int HDR_OP_MSB   = 15;
    localparam int HDR_OP_LSB   = 14;
    localparam int HDR_ADDR_MSB = 13;
    localparam int HDR_ADDR_LSB = 8;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 0;
    localparam int CNT_WIDTH    = 8;

    typedef enum logic [1:0] {
        OP_ILL    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_STATUS = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_REG  = 3'd2,
        RD_REG  = 3'd3,
        TX_LOAD = 3'd4,
        TX_WAIT = 3'd5,
        TX_GAP  = 3'd6,
        DRAIN   = 3'd7
    } state_e;

    typedef struct packed {
        opcode_e                           op;
        logic [HDR_ADDR_MSB:HDR_ADDR_LSB]  addr;
        logic [HDR_LEN_MSB:HDR_LEN_LSB]    len;
    } header_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================
// sync_2ff: generic two-flop synchronizer with reset value
// Revision: 1.0
// ============================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
// ============================================================
// spi_cmd_ctrl: SPI header-driven register burst sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  rx_valid,
    input  logic [DATA_SIZE-1:0]  rx_data,
    output logic                  tx_valid,
    output logic [DATA_SIZE-1:0]  tx_data,
    input  logic                  tx_ready,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_SIZE-1:0]  reg_wdata,
    input  logic [DATA_SIZE-1:0]  reg_rdata,
    input  logic                  reg_ack,
    output logic                  busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                 state;
    logic                   cs_s;
    logic                   cs_s_q;
    logic                   rx_v1;
    logic                   rx_v2;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [CNT_WIDTH-1:0]   frame_cnt;
    logic [CNT_WIDTH-1:0]   err_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   is_status;
    logic                   overrun;
    logic                   abort_pend;

    header_t                hdr;
    logic                   word_evt;
    logic                   cs_rise;
    logic                   abort_now;
    logic                   ovr_now;
    logic                   ill_now;
    logic                   err_inc;
    logic                   stop;
    logic                   last_word;
    logic                   gap_done;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs),
        .q     (cs_s)
    );

    assign hdr  = rx_data[HDR_WIDTH-1:0];
    assign busy = (state != IDLE);

    always_comb begin
        word_evt  = rx_v1 & ~rx_v2 & ~cs_s;
        cs_rise   = cs_s & ~cs_s_q;
        abort_now = cs_rise && (state != IDLE) && (state != DRAIN);
        ovr_now   = word_evt && (state == WR_REG) && !overrun && !abort_pend;
        ill_now   = word_evt && (state == IDLE) &&
                    ((hdr.op == OP_ILL) || ((hdr.op != OP_STATUS) && (hdr.len == '0)));
        // A frame contributes at most one error, whichever is seen first
        err_inc   = ill_now | ovr_now | (abort_now & ~overrun & ~abort_pend);
        stop      = abort_now | abort_pend;
        last_word = (remaining == LEN_WIDTH'(1));
        gap_done  = (int'(gap_cnt) + 1 >= GAP_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cs_s_q     <= 1'b1;
            rx_v1      <= 1'b0;
            rx_v2      <= 1'b0;
            remaining  <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            gap_cnt    <= '0;
            is_status  <= 1'b0;
            overrun    <= 1'b0;
            abort_pend <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
        end else begin
            rx_v1  <= rx_valid;
            rx_v2  <= rx_v1;
            cs_s_q <= cs_s;

            if (err_inc) err_cnt <= sat_inc(err_cnt);
            if (ovr_now) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    overrun    <= 1'b0;
                    abort_pend <= 1'b0;
                    if (word_evt) begin
                        reg_addr  <= ADDR_WIDTH'(hdr.addr);
                        remaining <= LEN_WIDTH'(hdr.len);
                        is_status <= 1'b0;
                        if (ill_now) begin
                            state <= DRAIN;
                        end else if (hdr.op == OP_WRITE) begin
                            state <= WR_DATA;
                        end else if (hdr.op == OP_READ) begin
                            reg_req <= 1'b1;
                            reg_we  <= 1'b0;
                            state   <= RD_REG;
                        end else begin
                            // tx_valid is raised on entry so it appears one cycle after the trigger
                            is_status <= 1'b1;
                            tx_data   <= DATA_SIZE'({frame_cnt, err_cnt});
                            tx_valid  <= 1'b1;
                            state     <= TX_LOAD;
                        end
                    end
                end

                WR_DATA: begin
                    if (abort_now) begin
                        state <= IDLE;
                    end else if (word_evt) begin
                        reg_wdata <= rx_data;
                        reg_req   <= 1'b1;
                        reg_we    <= 1'b1;
                        state     <= WR_REG;
                    end
                end

                WR_REG: begin
                    if (abort_now) abort_pend <= 1'b1;
                    if (reg_ack) begin
                        reg_req   <= 1'b0;
                        reg_addr  <= reg_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (stop) begin
                            state <= IDLE;
                        end else if (overrun || ovr_now) begin
                            state <= DRAIN;
                        end else if (last_word) begin
                            frame_cnt <= sat_inc(frame_cnt);
                            state     <= IDLE;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end

                RD_REG: begin
                    if (abort_now) abort_pend <= 1'b1;
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        if (stop) begin
                            state <= IDLE;
                        end else begin
                            tx_data  <= reg_rdata;
                            tx_valid <= 1'b1;
                            state    <= TX_LOAD;
                        end
                    end
                end

                TX_LOAD: begin
                    if (abort_now) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= TX_WAIT;
                    end
                end

                TX_WAIT: begin
                    if (abort_now) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= TX_GAP;
                    end
                end

                TX_GAP: begin
                    if (abort_now) begin
                        state <= IDLE;
                    end else if (gap_done) begin
                        gap_cnt <= '0;
                        if (is_status) begin
                            frame_cnt <= sat_inc(frame_cnt);
                            state     <= IDLE;
                        end else begin
                            reg_addr  <= reg_addr + ADDR_WIDTH'(1);
                            remaining <= remaining - LEN_WIDTH'(1);
                            if (last_word) begin
                                frame_cnt <= sat_inc(frame_cnt);
                                state     <= IDLE;
                            end else begin
                                reg_req <= 1'b1;
                                reg_we  <= 1'b0;
                                state   <= RD_REG;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                DRAIN: begin
                    if (cs_s) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
